// File: rtl/cw305_reg_mem_bridge.sv
// Byte-wide register block that lets the CW305 USB front-end issue single
// 32-bit read/write transactions on a req/ack memory port.
module cw305_reg_mem_bridge #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pTIMEOUT      = 255
) (
  input  logic                                 usb_clk,
  input  logic                                 rst,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  input  logic [7:0]                           reg_datao,
  output logic [7:0]                           reg_datai,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [31:0]                          mem_addr,
  output logic [31:0]                          mem_wdata,
  input  logic [31:0]                          mem_rdata,
  input  logic                                 mem_ack
);

  localparam int              RAW         = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam logic [RAW-1:0]  A_ADDR      = RAW'(0);
  localparam logic [RAW-1:0]  A_WDATA     = RAW'(1);
  localparam logic [RAW-1:0]  A_RDATA     = RAW'(2);
  localparam logic [RAW-1:0]  A_CTRL      = RAW'(3);
  localparam logic [7:0]      TIMEOUT_CNT = 8'(pTIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d, datai_q, datai_d;
  logic        we_q, we_d, autoinc_q, autoinc_d, done_q, done_d, to_q, to_d;
  logic        ctrl_wr_q;

  logic        busy, wr_ok, lane_ok, ctrl_wr, start, expire;
  logic [4:0]  lane_sel;
  logic [7:0]  cnt_inc, rd_byte;

  always_comb begin
    busy     = (state_q == S_WAIT);
    lane_ok  = (reg_bytecnt[pBYTECNT_SIZE-1:2] == '0);
    lane_sel = {reg_bytecnt[1:0], 3'b000};
    wr_ok    = reg_write & reg_addrvalid & lane_ok & ~busy;
    ctrl_wr  = reg_write & reg_addrvalid & (reg_address == A_CTRL) &
               (reg_bytecnt == '0);
    // Launch only on the first cycle of a CTRL write; held strobes must not relaunch.
    start    = ctrl_wr & ~ctrl_wr_q & reg_datao[0] & ~busy;
    cnt_inc  = cnt_q + 8'd1;
    expire   = (cnt_inc == TIMEOUT_CNT);
  end

  // NOTE: all state lives in always_ff with non-blocking assignments so every
  // flop samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_WAIT;
      S_WAIT: if (mem_ack || expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = busy;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    reg_datai = datai_q;
  end

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    autoinc_d = autoinc_q;
    done_d    = done_q;
    to_d      = to_q;
    if (wr_ok && reg_address == A_ADDR)  addr_d[lane_sel +: 8]  = reg_datao;
    if (wr_ok && reg_address == A_WDATA) wdata_d[lane_sel +: 8] = reg_datao;
    if (ctrl_wr && !busy) begin
      we_d      = reg_datao[1];
      autoinc_d = reg_datao[2];
    end
    if (start) begin
      cnt_d  = 8'd0;
      done_d = 1'b0;
      to_d   = 1'b0;
    end
    if (busy) begin
      cnt_d = cnt_inc;
      if (mem_ack) begin
        if (!we_q)     rdata_d = mem_rdata;
        if (autoinc_q) addr_d  = addr_q + 32'd4;
        done_d = 1'b1;
      end else if (expire) begin
        to_d   = 1'b1;
        done_d = 1'b0;
      end
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (reg_address)
      A_ADDR:  if (lane_ok) rd_byte = addr_q[lane_sel +: 8];
      A_WDATA: if (lane_ok) rd_byte = wdata_q[lane_sel +: 8];
      A_RDATA: if (lane_ok) rd_byte = rdata_q[lane_sel +: 8];
      A_CTRL:  if (reg_bytecnt == '0) rd_byte = {4'b0, autoinc_q, to_q, done_q, busy};
      default: rd_byte = 8'h00;
    endcase
    datai_d = (reg_read && reg_addrvalid) ? rd_byte : datai_q;
  end

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      datai_q   <= '0;
      we_q      <= 1'b0;
      autoinc_q <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      ctrl_wr_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      datai_q   <= datai_d;
      we_q      <= we_d;
      autoinc_q <= autoinc_d;
      done_q    <= done_d;
      to_q      <= to_d;
      ctrl_wr_q <= ctrl_wr;
    end
  end

endmodule

// File: tb/tb_cw305_reg_mem_bridge.sv
// Directed plus randomized bench for cw305_reg_mem_bridge, scored against a
// transaction-level model of the register map and memory port.
module tb_cw305_reg_mem_bridge;

  localparam int TO = 8;

  logic        usb_clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] reg_address = '0;
  logic [6:0]  reg_bytecnt = '0;
  logic [7:0]  reg_datao = '0;
  logic [7:0]  reg_datai;
  logic        reg_read = 1'b0, reg_write = 1'b0, reg_addrvalid = 1'b1;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  cw305_reg_mem_bridge #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pTIMEOUT(TO)) dut (
    .usb_clk(usb_clk), .rst(rst), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
    .reg_datao(reg_datao), .reg_datai(reg_datai), .reg_read(reg_read),
    .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0, errors = 0, req_rises = 0;
  always @(posedge mem_req) req_rises++;

  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic        m_done = 1'b0, m_to = 1'b0, m_ai = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic reg_wr(input int a, input int b, input logic [7:0] d);
    reg_address = 14'(a); reg_bytecnt = 7'(b); reg_datao = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic reg_rd(input int a, input int b, output logic [7:0] d);
    reg_address = 14'(a); reg_bytecnt = 7'(b); reg_read = 1'b1;
    tick();
    d = reg_datai;
    reg_read = 1'b0;
  endtask

  task automatic wr32(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) reg_wr(a, i, v[8*i +: 8]);
  endtask

  task automatic rd32(input int a, output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      reg_rd(a, i, b);
      v[8*i +: 8] = b;
    end
  endtask

  function automatic logic [7:0] exp_ctrl();
    return {4'b0, m_ai, m_to, m_done, 1'b0};
  endfunction

  task automatic check_regs(input string tag);
    logic [31:0] v;
    logic [7:0]  c;
    rd32(0, v); check({tag, " ADDR"}, v, m_addr);
    rd32(1, v); check({tag, " WDATA"}, v, m_wdata);
    rd32(2, v); check({tag, " RDATA"}, v, m_rdata);
    reg_rd(3, 0, c); check({tag, " CTRL"}, 32'(c), 32'(exp_ctrl()));
  endtask

  // One host-launched transaction; ack_dly = WAIT cycle index that sees mem_ack.
  task automatic run_op(input string tag, input logic [7:0] ctrl, input int ack_dly,
                        input logic [31:0] rd_val);
    int n, r0;
    r0 = req_rises;
    reg_wr(3, 0, ctrl);
    check({tag, " req"}, 32'(mem_req), 32'd1);
    check({tag, " we"}, 32'(mem_we), 32'(ctrl[1]));
    check({tag, " addr"}, mem_addr, m_addr);
    if (ctrl[1]) check({tag, " wdata"}, mem_wdata, m_wdata);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      if (n == ack_dly) begin
        mem_ack = 1'b1; mem_rdata = rd_val;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      n++;
    end
    check({tag, " req cycles"}, 32'(n), 32'((ack_dly < TO) ? ack_dly + 1 : TO));
    check({tag, " req pulses"}, 32'(req_rises - r0), 32'd1);
    m_ai = ctrl[2];
    if (ack_dly < TO) begin
      if (!ctrl[1]) m_rdata = rd_val;
      if (ctrl[2]) m_addr = m_addr + 32'd4;
      m_done = 1'b1; m_to = 1'b0;
    end else begin
      m_done = 1'b0; m_to = 1'b1;
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] v;
    int          r0, n;

    repeat (2) tick();
    check("reset req", 32'(mem_req), 32'd0);
    check("reset addr", mem_addr, 32'd0);
    check("reset datai", 32'(reg_datai), 32'd0);
    rst = 1'b0;
    tick();

    // Directed write transaction
    m_wdata = 32'hDEADBEEF; m_addr = 32'h20000010;
    wr32(0, m_addr); wr32(1, m_wdata);
    run_op("t1", 8'h03, 3, 32'h0);
    reg_rd(3, 0, b); check("t1 ctrl", 32'(b), 32'h02);
    check_regs("t1");

    // Directed read: byte lanes and reg_datai hold
    run_op("t2", 8'h01, 1, 32'h12345678);
    reg_rd(2, 0, b); check("t2 b0", 32'(b), 32'h78);
    reg_rd(2, 1, b); check("t2 b1", 32'(b), 32'h56);
    reg_rd(2, 2, b); check("t2 b2", 32'(b), 32'h34);
    reg_rd(2, 3, b); check("t2 b3", 32'(b), 32'h12);
    tick(); check("t2 datai hold", 32'(reg_datai), 32'h12);

    // Address decode boundaries
    reg_rd(2, 4, b); check("lane4 read", 32'(b), 32'h00);
    reg_rd(7, 0, b); check("unmapped read", 32'(b), 32'h00);
    reg_wr(0, 5, 8'hAA);
    reg_addrvalid = 1'b0; reg_wr(1, 0, 8'h11); reg_rd(2, 0, b); reg_addrvalid = 1'b1;
    check("addrvalid low read holds", 32'(b), 32'h00);
    check_regs("decode");

    // Autoincrement across the 32-bit wrap
    m_addr = 32'hFFFFFFFC; wr32(0, m_addr);
    run_op("t3a", 8'h05, 0, 32'hCAFEF00D);
    run_op("t3b", 8'h05, 2, 32'h0BADC0DE);
    rd32(0, v); check("t3 addr", v, 32'h00000004);

    // Timeout, then the next START clears it
    run_op("t4", 8'h01, 20, 32'h0);
    reg_rd(3, 0, b); check("t4 ctrl", 32'(b), 32'h04);
    run_op("t4b", 8'h01, 0, 32'h5A5A0001);
    reg_rd(3, 0, b); check("t4b ctrl", 32'(b), 32'h02);

    // Level-held CTRL write launches exactly once
    r0 = req_rises;
    reg_address = 14'd3; reg_bytecnt = '0; reg_datao = 8'h01; reg_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ack = (i == 2); mem_rdata = 32'hA5A5A5A5;
      tick();
    end
    reg_write = 1'b0; mem_ack = 1'b0;
    check("t5 held pulses", 32'(req_rises - r0), 32'd1);
    m_rdata = 32'hA5A5A5A5; m_done = 1'b1; m_to = 1'b0; m_ai = 1'b0;
    check_regs("t5 held");

    // Writes and START while BUSY are ignored
    r0 = req_rises;
    reg_wr(3, 0, 8'h01);
    wr32(0, 32'h55555555);
    reg_wr(3, 0, 8'h07);
    reg_rd(3, 0, b); check("t5 busy ctrl", 32'(b), 32'h01);
    check("t5 busy we", 32'(mem_we), 32'd0);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin tick(); n++; end
    check("t5 busy pulses", 32'(req_rises - r0), 32'd1);
    m_done = 1'b0; m_to = 1'b1;
    check_regs("t5 busy");

    // Randomized transactions
    for (int it = 0; it < 24; it++) begin
      logic [7:0] ctrl;
      if ($urandom_range(0, 1) == 1) begin
        m_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 | 32'($urandom_range(0, 7))
                                             : $urandom;
        wr32(0, m_addr);
      end
      m_wdata = $urandom; wr32(1, m_wdata);
      ctrl = {5'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      run_op("rand", ctrl, $urandom_range(0, 11), $urandom);
      reg_rd(3, 0, b); check("rand ctrl", 32'(b), 32'(exp_ctrl()));
      rd32(0, v); check("rand addr", v, m_addr);
      rd32(2, v); check("rand rdata", v, m_rdata);
    end

    // Asynchronous reset mid-transaction, late ack afterwards
    wr32(0, 32'h12340000);
    reg_wr(3, 0, 8'h07);
    tick(); tick();
    #3 rst = 1'b1;
    #1 check("t6 req async drop", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b0;
    r0 = req_rises;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    tick();
    check("t6 no req after release", 32'(req_rises - r0), 32'd0);
    check("t6 req", 32'(mem_req), 32'd0);
    check("t6 we", 32'(mem_we), 32'd0);
    check("t6 datai", 32'(reg_datai), 32'd0);
    check("t6 mem_addr", mem_addr, 32'd0);
    check("t6 mem_wdata", mem_wdata, 32'd0);
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_done = 1'b0; m_to = 1'b0; m_ai = 1'b0;
    check_regs("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
